// File: rtl/rgb2bram_pkg.sv
// Shared types and defaults for the rgb2bram video-to-BRAM capture block.
// Build option RGB2BRAM_DECIM_EN selects 2:1 decimation on both axes.
package rgb2bram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FULL    = 2'd3
    } state_t;

    typedef struct packed {
        state_t state;
        logic   hd;
    } dbg_t;

    localparam int H_CAP_DEF = 320;
    localparam int V_CAP_DEF = 180;
    localparam int DEPTH     = H_CAP_DEF * V_CAP_DEF;
    localparam int ADDR_W    = 20;
    localparam int PIX_W     = 24;

endpackage

// File: rtl/vid_edge_det.sv
// Registered-history edge detector for vertical sync (already polarity
// normalised) and data enable; history only advances while en is high.
module vid_edge_det (
    input  logic clk,
    input  logic xrst,
    input  logic en,
    input  logic vs,
    input  logic den,
    output logic vs_rise,
    output logic vs_fall,
    output logic den_rise,
    output logic den_fall
);

    logic vs_q;
    logic den_q;

    always_ff @(posedge clk) begin
        if (!xrst) begin
            vs_q  <= 1'b0;
            den_q <= 1'b0;
        end else if (en) begin
            vs_q  <= vs;
            den_q <= den;
        end
    end

    assign vs_rise  = vs & ~vs_q;
    assign vs_fall  = ~vs & vs_q;
    assign den_rise = den & ~den_q;
    assign den_fall = ~den & den_q;

endmodule

// File: rtl/rgb2bram.sv
// Captures an H_CAP x V_CAP window of a DE-framed RGB stream into BRAM, one
// write per kept pixel. Define RGB2BRAM_DECIM_EN to keep only even pixels of even lines.
module rgb2bram
    import rgb2bram_pkg::*;
#(
    parameter int   H_CAP = H_CAP_DEF,
    parameter int   V_CAP = V_CAP_DEF,
    parameter logic VSP   = 1'b1
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              en,
    input  logic              vd,
    input  logic              hd,
    input  logic              den,
    input  logic [PIX_W-1:0]  rgb24bit,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_we,
    output logic              frame_done,
    output logic              frame_short,
    output dbg_t              dbg
);

`ifdef RGB2BRAM_DECIM_EN
    localparam logic DECIM = 1'b1;
`else
    localparam logic DECIM = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] H_LIM  = ADDR_W'(H_CAP);
    localparam logic [ADDR_W-1:0] V_LIM  = ADDR_W'(V_CAP);
    localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_CAP - 1);

    state_t state, state_nx;
    logic [ADDR_W-1:0] x, y, base;
    logic vs, vs_rise, vs_fall, den_rise, den_fall;
    logic vs_left, src_x_odd, src_y_odd;
    logic we_q, done_q, short_q, hd_q;
    logic keep_px, keep_line;
    logic start, abort, line_end, frame_full, wr;

    assign vs = (vd == VSP);

    vid_edge_det u_edge (
        .clk      (clk),
        .xrst     (xrst),
        .en       (en),
        .vs       (vs),
        .den      (den),
        .vs_rise  (vs_rise),
        .vs_fall  (vs_fall),
        .den_rise (den_rise),
        .den_fall (den_fall)
    );

    assign keep_px   = ~DECIM | ~src_x_odd;
    assign keep_line = ~DECIM | ~src_y_odd;

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        abort      = 1'b0;
        line_end   = 1'b0;
        frame_full = 1'b0;
        case (state)
            IDLE:    if (vs_rise) state_nx = ARMED;
            ARMED: begin
                // Capture only begins once sync has been seen to end.
                if (den_rise && !vs && (vs_left || vs_fall)) begin
                    start    = 1'b1;
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    abort    = 1'b1;
                    state_nx = ARMED;
                end else if (den_fall) begin
                    line_end = 1'b1;
                    if (keep_line && y == V_LAST) begin
                        frame_full = 1'b1;
                        state_nx   = FULL;
                    end
                end
            end
            FULL:    if (vs_rise) state_nx = ARMED;
            default: state_nx = IDLE;
        endcase
        wr = (start || (state == CAPTURE && !vs_rise)) && den && keep_px && keep_line
             && (x < H_LIM) && (y < V_LIM);
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            base      <= '0;
            vs_left   <= 1'b0;
            src_x_odd <= 1'b0;
            src_y_odd <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            hd_q      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (en) begin
            state   <= state_nx;
            hd_q    <= hd;
            we_q    <= wr;
            done_q  <= abort | frame_full;
            short_q <= abort;
            if (wr) begin
                ram_addr  <= base + x;
                ram_wdata <= rgb24bit;
            end
            if (state_nx == ARMED) begin
                x         <= '0;
                y         <= '0;
                base      <= '0;
                src_x_odd <= 1'b0;
                src_y_odd <= 1'b0;
                if (vs_rise)      vs_left <= 1'b0;
                else if (vs_fall) vs_left <= 1'b1;
            end else if (start || state == CAPTURE) begin
                if (line_end) begin
                    x         <= '0;
                    src_x_odd <= 1'b0;
                    src_y_odd <= ~src_y_odd;
                    if (keep_line) begin
                        y    <= y + 1'b1;
                        base <= base + H_LIM;
                    end
                end else if (den) begin
                    src_x_odd <= ~src_x_odd;
                    if (keep_px && keep_line && x < H_LIM) x <= x + 1'b1;
                end
            end
        end
    end

    // Held strobes are masked while stalled so a pause never repeats a write.
    assign ram_we      = we_q & en;
    assign frame_done  = done_q & en;
    assign frame_short = short_q & en;
    assign dbg         = '{state: state, hd: hd_q};

endmodule

// File: tb/tb_rgb2bram.sv
// Scenario bench for rgb2bram on a reduced 10x6 window fed with 24x14 source frames;
// writes are collected and compared against a pixel-coordinate model.
module tb_rgb2bram;
    import rgb2bram_pkg::*;

    localparam int H      = 10;
    localparam int V      = 6;
    localparam int SRC_W  = 24;
    localparam int SRC_H  = 14;
    localparam int HBLANK = 3;
    localparam int PAUSE  = 50;
    localparam logic [19:0] MAX_ADDR = 20'(H * V - 1);

    logic        clk = 1'b0;
    logic        xrst, en, vd, hd, den;
    logic [23:0] rgb24bit;
    logic [19:0] ram_addr;
    logic [23:0] ram_wdata;
    logic        ram_we, frame_done, frame_short;
    dbg_t        dbg;

    logic [43:0] exp_q[$];
    logic [43:0] got_q[$];
    int total = 0, bad = 0;
    int done_cnt, short_cnt, both_cnt, pause_we, over_cnt;

    rgb2bram #(.H_CAP(H), .V_CAP(V), .VSP(1'b1)) dut (
        .clk(clk), .xrst(xrst), .en(en), .vd(vd), .hd(hd), .den(den),
        .rgb24bit(rgb24bit), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .frame_done(frame_done), .frame_short(frame_short), .dbg(dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            got_q.push_back({ram_addr, ram_wdata});
            if (ram_addr > MAX_ADDR) over_cnt++;
        end
        if (ram_we && !en) pause_we++;
        if (frame_done) done_cnt++;
        if (frame_short) short_cnt++;
        if (frame_done && frame_short) both_cnt++;
    end

    // Reference: source pixel (sx,sy) lands at cy*H+cx when inside the window.
    function automatic void model_pixel(input int sx, input int sy, input logic [23:0] d);
        int cx, cy;
        bit keep;
`ifdef RGB2BRAM_DECIM_EN
        keep = (sx % 2 == 0) && (sy % 2 == 0);
        cx = sx / 2;
        cy = sy / 2;
`else
        keep = 1'b1;
        cx = sx;
        cy = sy;
`endif
        if (keep && cx < H && cy < V) exp_q.push_back({20'(cy * H + cx), d});
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        done_cnt = 0; short_cnt = 0; both_cnt = 0; pause_we = 0; over_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        den = 1'b0; hd = 1'b0; vd = 1'b1;
        repeat (3) tick();
        vd = 1'b0;
        repeat (2) tick();
    endtask

    task automatic drive_line(input int sy, input bit cap, input int pause_px, input int stop_px);
        logic [23:0] d;
        for (int sx = 0; sx < SRC_W; sx++) begin
            d = 24'($urandom);
            vd = 1'b0; den = 1'b1; hd = (sx == 0); rgb24bit = d;
            if (sx == pause_px) begin
                en = 1'b0;
                repeat (PAUSE) @(posedge clk);
                #1;
                en = 1'b1;
            end
            tick();
            if (cap) model_pixel(sx, sy, d);
            if (sx == stop_px) begin
                den = 1'b0;
                return;
            end
        end
        den = 1'b0; hd = 1'b0; rgb24bit = 24'($urandom);
        repeat (HBLANK) tick();
    endtask

    task automatic drive_frame(input int pause_line, input int pause_px);
        vsync_pulse();
        for (int sy = 0; sy < SRC_H; sy++)
            drive_line(sy, 1'b1, (sy == pause_line) ? pause_px : -1, -1);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        xrst = 1'b0; en = 1'b1; vd = 1'b0; hd = 1'b0; den = 1'b0; rgb24bit = '0;
        repeat (3) tick();
        total++; if (ram_addr !== 20'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", ram_addr); end
        total++; if (ram_wdata !== 24'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", ram_wdata); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", ram_we); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done); end
        total++; if (frame_short !== 1'b0) begin bad++; $display("FAIL rst_short got=%b exp=0", frame_short); end
        total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg.state, IDLE); end
        xrst = 1'b1;
        tick();
    endtask

    task automatic test_mid_frame();
        clear_sb();
        for (int sy = 5; sy < 9; sy++) drive_line(sy, 1'b0, -1, -1);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL mid_nowrite got=%0d exp=0", got_q.size()); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL mid_nodone got=%0d exp=0", done_cnt); end
        drive_frame(-1, -1);
        total++; if (got_q.size() != H * V) begin bad++; $display("FAIL mid_count got=%0d exp=%0d", got_q.size(), H * V); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL mid_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); break;
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL mid_done got=%0d exp=1", done_cnt); end
        total++; if (short_cnt != 0) begin bad++; $display("FAIL mid_short got=%0d exp=0", short_cnt); end
        total++; if (dbg.state !== FULL) begin bad++; $display("FAIL mid_state got=%0d exp=%0d", dbg.state, FULL); end
    endtask

    task automatic test_full_frame();
        clear_sb();
        drive_frame(-1, -1);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL full_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); break;
            end
        end
        if (got_q.size() > 0) begin
            total++;
            if (got_q[got_q.size() - 1][43:24] !== MAX_ADDR) begin
                bad++; $display("FAIL full_last_addr got=%0d exp=%0d", got_q[got_q.size() - 1][43:24], MAX_ADDR);
            end
        end
        total++; if (over_cnt != 0) begin bad++; $display("FAIL full_addr_range got=%0d exp=0", over_cnt); end
        total++; if (done_cnt != 1 || short_cnt != 0) begin bad++; $display("FAIL full_pulses got=%0d/%0d exp=1/0", done_cnt, short_cnt); end
    endtask

    task automatic test_abort();
        clear_sb();
        vsync_pulse();
        for (int sy = 0; sy < 3; sy++) drive_line(sy, 1'b1, -1, -1);
        vd = 1'b1; den = 1'b1; rgb24bit = 24'($urandom);
        tick();
        den = 1'b0;
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b exp=1", frame_done); end
        total++; if (frame_short !== 1'b1) begin bad++; $display("FAIL abort_short got=%b exp=1", frame_short); end
        total++; if (dbg.state !== ARMED) begin bad++; $display("FAIL abort_state got=%0d exp=%0d", dbg.state, ARMED); end
        tick();
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL abort_pulse_width got=%b exp=0", frame_done); end
        vd = 1'b0;
        repeat (3) tick();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL abort_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL abort_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); break;
            end
        end
        total++; if (both_cnt != 1 || done_cnt != 1) begin bad++; $display("FAIL abort_pulses got=%0d/%0d exp=1/1", both_cnt, done_cnt); end
    endtask

    task automatic test_en_pause();
        clear_sb();
        drive_frame(2, 3);
        total++; if (pause_we != 0) begin bad++; $display("FAIL pause_we got=%0d exp=0", pause_we); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL pause_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL pause_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); break;
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL pause_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        vsync_pulse();
        drive_line(0, 1'b1, -1, -1);
        drive_line(1, 1'b1, -1, -1);
        drive_line(2, 1'b1, -1, 4);
        xrst = 1'b0;
        tick();
        total++; if (ram_addr !== 20'd0) begin bad++; $display("FAIL rmid_addr got=%h exp=0", ram_addr); end
        total++; if (ram_wdata !== 24'd0) begin bad++; $display("FAIL rmid_wdata got=%h exp=0", ram_wdata); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b exp=0", ram_we); end
        total++; if (frame_done !== 1'b0 || frame_short !== 1'b0) begin bad++; $display("FAIL rmid_pulses got=%b%b exp=00", frame_done, frame_short); end
        total++; if (dbg.state !== IDLE) begin bad++; $display("FAIL rmid_state got=%0d exp=%0d", dbg.state, IDLE); end
        xrst = 1'b1;
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rmid_pre_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rmid_pre_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); break;
            end
        end
        clear_sb();
        for (int sy = 3; sy < SRC_H; sy++) drive_line(sy, 1'b0, -1, -1);
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rmid_nowrite got=%0d exp=0", got_q.size()); end
        drive_frame(-1, -1);
        if (got_q.size() > 0) begin
            total++;
            if (got_q[0][43:24] !== 20'd0) begin bad++; $display("FAIL rmid_first_addr got=%0d exp=0", got_q[0][43:24]); end
        end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rmid_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mid_frame();
        test_full_frame();
        test_abort();
        test_en_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb2bram.md
RGB2BRAM -- requirements
Module: rgb2bram

Interface
REQ-001 SHALL have parameter H_CAP, default 320, meaning captured pixels per line.
REQ-002 SHALL have parameter V_CAP, default 180, meaning captured lines per frame.
REQ-003 SHALL have parameter VSP, default 1, meaning vd level that marks vertical sync active.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port xrst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: clock enable; when low, all state holds and ram_we=0.
REQ-007 SHALL have ports vd, hd, den, input, 1 bit each: incoming video vertical sync, horizontal sync and data enable.
REQ-008 SHALL have port rgb24bit, input, 24 bits: pixel data, valid when den=1.
REQ-009 SHALL have port ram_addr, output, 20 bits: BRAM write address.
REQ-010 SHALL have port ram_wdata, output, 24 bits: BRAM write data.
REQ-011 SHALL have port ram_we, output, 1 bit: BRAM write strobe, one write per cycle high.
REQ-012 SHALL have ports frame_done and frame_short, output, 1 bit each: single-cycle end-of-frame status pulses.

Function
REQ-013 SHALL implement states IDLE, ARMED, CAPTURE, FULL.
REQ-014 IDLE -> ARMED on the cycle vd enters VSP level (edge, not level), so a partial first frame is never written.
REQ-015 ARMED -> CAPTURE on the first den rising edge after vd leaves VSP level; line counter y=0, pixel counter x=0, address base=0.
REQ-016 In CAPTURE, each cycle with den=1, x<H_CAP and y<V_CAP SHALL register ram_we=1, ram_wdata=rgb24bit, ram_addr=y*H_CAP+x, one cycle after the sample (latency 1).
REQ-017 Address SHALL be generated incrementally (line base += H_CAP per line); no multiplier.
REQ-018 x SHALL increment on every den=1 cycle and saturate at H_CAP; pixels beyond H_CAP SHALL be dropped without writing.
REQ-019 Each den falling edge SHALL clear x and increment y; on y reaching V_CAP, the state SHALL move to FULL.
REQ-020 Entering FULL SHALL pulse frame_done for one cycle; the last write (address H_CAP*V_CAP-1) SHALL precede or coincide with that pulse.
REQ-021 FULL -> ARMED on the next vd edge into VSP level.
REQ-022 A vd edge into VSP level during CAPTURE SHALL abort the frame: pulse frame_done and frame_short together, then go to ARMED; vsync wins over a simultaneous den.
REQ-023 ram_addr SHALL never exceed H_CAP*V_CAP-1; hd is sampled only for diagnostics and SHALL NOT affect addressing.

Reset
REQ-024 xrst=0 at a rising clk edge SHALL force IDLE, x=y=0, ram_addr=0, ram_wdata=0, ram_we=0, frame_done=0, frame_short=0, including mid-frame.
REQ-025 Reset SHALL take priority over en.

Configuration
REQ-026 With RGB2BRAM_DECIM_EN defined, only even-indexed pixels of even-indexed source lines SHALL be written (2:1 each axis; x, y and address count kept samples only).
REQ-027 Without RGB2BRAM_DECIM_EN, every source pixel/line within the window SHALL be written.

Structure
REQ-028 Package rgb2bram_pkg SHALL hold the state typedef, default H_CAP/V_CAP and DEPTH = H_CAP*V_CAP (57600).
REQ-029 Sub-module vid_edge_det SHALL provide registered rise/fall detection of vd and den.

Verification
REQ-030 640x480 frame at den, after one vsync -> 57600 writes, addresses 0..57599 in order, ram_wdata matches pixel (x,y) at y*320+x, one frame_done, frame_short=0.
REQ-031 Stream starting mid-frame -> zero writes until after the first vd edge.
REQ-032 vd asserted after 100 lines -> 32000 writes, then frame_done=frame_short=1 in the same cycle, state ARMED.
REQ-033 en low for 50 cycles mid-line -> no writes in that window, address continues without gap once en returns.
REQ-034 xrst low at address 1000 -> next cycle all outputs 0; the following frame restarts at address 0 only after a new vsync.
REQ-035 With RGB2BRAM_DECIM_EN -> writes go to (x/2,y/2) for even x and y; 57600 writes for 640x360 active region.
